// File: rtl/frame_checker_rx.sv
// frame_checker_rx: aligns to a repeating test frame of 66-bit blocks and counts block errors and good frames
//   i_clock            rising-edge clock for all state
//   i_reset_n          asynchronous active-low reset
//   i_enable           global enable; low freezes all state
//   i_valid            i_data carries a block this cycle
//   i_data             received block, [65:64] sync header, [63:56] first byte
//   i_clear            synchronous clear of both statistics counters
//   o_lock             frame alignment held
//   o_block_error      one-cycle pulse per mismatching block accepted while locked
//   o_error_count      saturating count of mismatching blocks while locked
//   o_good_frame_count saturating count of complete error-free frames
module frame_checker_rx #(
    parameter int AM_BLOCK_PERIOD   = 16383,
    parameter int FRAMES_PER_PERIOD = 10,
    parameter int FRAME_LEN         = AM_BLOCK_PERIOD / FRAMES_PER_PERIOD,
    parameter int N_DATA_FRAMES     = 1000,
    parameter int NB_MISS_LOCK      = 4,
    parameter int NB_DATA           = 66,
    parameter int NB_COUNT          = 32
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic                i_clear,
    output logic                o_lock,
    output logic                o_block_error,
    output logic [NB_COUNT-1:0] o_error_count,
    output logic [NB_COUNT-1:0] o_good_frame_count
);
    localparam int NB_POS  = $clog2(FRAME_LEN);
    localparam int NB_MISS = $clog2(NB_MISS_LOCK + 1);
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    localparam logic [NB_POS-1:0]  LAST_POS   = NB_POS'(FRAME_LEN - 1);
    localparam logic [NB_POS-1:0]  DATA_LAST  = NB_POS'(N_DATA_FRAMES);
    localparam logic [NB_POS-1:0]  TERM_FIRST = NB_POS'(FRAME_LEN - 2);
    localparam logic [NB_MISS-1:0] MISS_LAST  = NB_MISS'(NB_MISS_LOCK - 1);
    localparam logic [NB_DATA-1:0] BLK_START  = {2'b10, 8'hFB, {7{8'hFA}}};
    localparam logic [NB_DATA-1:0] BLK_DATA   = {2'b01, {8{8'hFA}}};
    localparam logic [NB_DATA-1:0] BLK_IDLE   = {2'b10, 8'h1E, 56'h0};
    localparam logic [NB_DATA-1:0] BLK_TERM   = {2'b10, 8'h87, 56'h0};

    logic [0:0]          r_state;
    logic [NB_POS-1:0]   r_pos;
    logic [NB_MISS-1:0]  r_miss;
    logic                r_flag;
    logic                r_block_error;
    logic [NB_COUNT-1:0] r_error_count;
    logic [NB_COUNT-1:0] r_good_count;

    logic                w_accept;
    logic                w_locked;
    logic                w_last;
    logic                w_match;
    logic                w_miss;
    logic                w_good;
    logic [NB_DATA-1:0]  w_expected;

    always_comb begin
        w_expected = r_pos == '0 ? BLK_START :
                     r_pos <= DATA_LAST ? BLK_DATA :
                     r_pos < TERM_FIRST ? BLK_IDLE : BLK_TERM;
        w_accept   = i_enable && i_valid;
        w_locked   = r_state == LOCKED;
        w_last     = r_pos == LAST_POS;
        w_match    = i_data == w_expected;
        w_miss     = w_accept && w_locked && !w_match;
        // the frame's own last block must also match to count as good
        w_good     = w_accept && w_locked && w_last && w_match && !r_flag;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= HUNT;
            r_pos         <= '0;
            r_miss        <= '0;
            r_flag        <= 1'b0;
            r_block_error <= 1'b0;
            r_error_count <= '0;
            r_good_count  <= '0;
        end else begin
            r_block_error <= w_miss;
            if (w_accept && !w_locked && i_data == BLK_START) begin
                r_state <= LOCKED;
                r_pos   <= NB_POS'(1);
                r_miss  <= '0;
                r_flag  <= 1'b0;
            end else if (w_accept && w_locked) begin
                r_pos  <= w_last ? '0 : r_pos + 1'b1;
                r_flag <= !w_last && (r_flag || !w_match);
                r_miss <= w_match ? '0 : r_miss + 1'b1;
                if (!w_match && r_miss == MISS_LAST) begin
                    r_state <= HUNT;
                    r_pos   <= '0;
                end
            end
            // clear takes priority over a same-cycle increment
            if (i_clear) begin
                r_error_count <= '0;
                r_good_count  <= '0;
            end else begin
                if (w_miss && r_error_count != '1)
                    r_error_count <= r_error_count + 1'b1;
                if (w_good && r_good_count != '1)
                    r_good_count <= r_good_count + 1'b1;
            end
        end
    end

    assign o_lock             = r_state == LOCKED;
    assign o_block_error      = r_block_error;
    assign o_error_count      = r_error_count;
    assign o_good_frame_count = r_good_count;
endmodule

// File: doc/frame_checker_rx.md
FRAME_CHECKER_RX -- requirements
Module: frame_checker_rx

Interface
REQ-001 SHALL have parameter AM_BLOCK_PERIOD, default 16383, alignment-marker block period.
REQ-002 SHALL have parameter FRAMES_PER_PERIOD, default 10, test frames per AM period.
REQ-003 SHALL have parameter FRAME_LEN, default AM_BLOCK_PERIOD/FRAMES_PER_PERIOD (1638), blocks per test frame.
REQ-004 SHALL have parameter N_DATA_FRAMES, default 1000, data blocks per frame.
REQ-005 SHALL have parameter NB_MISS_LOCK, default 4, consecutive mismatches that drop lock.
REQ-006 SHALL have parameter NB_DATA, default 66, block width; NB_COUNT, default 32, statistics counter width.
REQ-007 SHALL have port i_clock, input, 1, the single clock; all state on its rising edge.
REQ-008 SHALL have port i_reset_n, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port i_enable, input, 1, global enable; low freezes all state.
REQ-010 SHALL have port i_valid, input, 1, i_data carries a block this cycle.
REQ-011 SHALL have port i_data, input, NB_DATA, received 66-bit block; [65:64] sync header, [63:56] first byte.
REQ-012 SHALL have port i_clear, input, 1, synchronous clear of statistics counters.
REQ-013 SHALL have port o_lock, output, 1, high while frame alignment is held.
REQ-014 SHALL have port o_block_error, output, 1, one-cycle pulse per mismatching accepted block while locked.
REQ-015 SHALL have port o_error_count, output, NB_COUNT, total mismatching blocks while locked.
REQ-016 SHALL have port o_good_frame_count, output, NB_COUNT, complete error-free frames.

Function
REQ-017 A block SHALL be accepted only on cycles with i_enable && i_valid; no other cycle changes position, FSM or counters (except i_clear, o_block_error).
REQ-018 Expected block at position p (0..FRAME_LEN-1): p=0 START {2'b10, 8'hFB, 7 x 8'hFA}; 1<=p<=N_DATA_FRAMES DATA {2'b01, 8 x 8'hFA}; N_DATA_FRAMES<p<FRAME_LEN-2 IDLE {2'b10, 8'h1E, 56'h0}; p>=FRAME_LEN-2 TERMINATE {2'b10, 8'h87, 56'h0}.
REQ-019 FSM states SHALL be HUNT and LOCKED; reset state HUNT.
REQ-020 HUNT: accepted block equal to START SHALL move to LOCKED, set position to 1, clear miss counter and frame-error flag; any other block stays in HUNT with no counting.
REQ-021 LOCKED: each accepted block SHALL be compared in full (66 bits) to expected at current position; position then increments, wrapping FRAME_LEN-1 -> 0.
REQ-022 LOCKED match SHALL clear the consecutive-miss counter.
REQ-023 LOCKED mismatch SHALL pulse o_block_error next cycle, increment o_error_count, set frame-error flag, increment miss counter.
REQ-024 Reaching NB_MISS_LOCK consecutive misses SHALL move to HUNT; o_lock low from the following cycle.
REQ-025 On accepting position FRAME_LEN-1, o_good_frame_count SHALL increment if frame-error flag (including this block) is clear; flag then clears.
REQ-026 o_lock SHALL be registered, high the cycle after the START that entered LOCKED.
REQ-027 All outputs SHALL be registered; latency accepted block -> outputs is 1 cycle.
REQ-028 Counters SHALL saturate at all-ones, never wrap.
REQ-029 i_clear SHALL zero both counters next cycle; clear wins over simultaneous increment; FSM, position unaffected.
REQ-030 o_block_error SHALL be low on any cycle without a mismatch accepted the previous cycle, including i_enable low.
REQ-031 Mismatches in HUNT SHALL not count; lock loss SHALL not reset counters.

Reset
REQ-032 i_reset_n low SHALL immediately force HUNT, position 0, miss counter 0, flag 0, o_lock 0, o_block_error 0, both counters 0, regardless of clock or i_enable.
REQ-033 Reset mid-frame SHALL discard partial frame; after release, checking resumes only from next START.

Verification
REQ-034 Assert i_reset_n low mid-stream -> all outputs 0 same cycle; after release, non-START blocks keep o_lock 0.
REQ-035 Clean stream from START, i_valid always high, 2*1638 blocks -> o_lock high cycle after START, o_error_count 0, o_good_frame_count 2.
REQ-036 Corrupt one DATA block at p=500 (flip bit 0) -> single o_block_error pulse, o_error_count 1, o_lock stays 1, that frame not counted, next frame counted.
REQ-037 Corrupt 4 consecutive blocks at p=10..13 -> 4 pulses, o_error_count 4, o_lock 0 after 4th; next START relocks, count unchanged.
REQ-038 Clean stream with i_valid low every 3rd cycle and i_enable low bursts -> no errors, frame count increments every 1638 accepted blocks.
REQ-039 i_clear together with a mismatch -> o_error_count 0 next cycle, o_block_error still pulses, o_lock unchanged.
